logic_wave_sequencer: RTL and testbench
=======================================

LOGIC_WAVE_SEQUENCER -- requirements
Module: logic_wave_sequencer

Interface
REQ-001 Parameter NUM_CH, 7: number of probe channels; each channel gets one 64-pixel-high display band.
REQ-002 Parameter NUM_SAMPLES, 80: capture depth; one 8-pixel tile column per sample on a 640-pixel line.
REQ-003 clk  in  1  single system/pixel clock; all logic on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 probe  in  NUM_CH  raw logic-analyzer inputs, already synchronized to clk.
REQ-006 sample_tick  in  1  one-cycle sampling strobe.
REQ-007 arm  in  1  one-cycle pulse that requests a new capture.
REQ-008 trig_sel  in  3  trigger channel 0..6; value 7 means force trigger.
REQ-009 video_on  in  1  VGA active-area flag for the current pixel_x/pixel_y.
REQ-010 pixel_x, pixel_y  in  10 each  current VGA pixel coordinates.
REQ-011 rom_addr  out  8  square-wave ROM address; bits 7:6 are {previous sample, current sample} and bits 5:0 are the tile row.
REQ-012 rom_data  in  8  ROM data, valid one clk after rom_addr (the ROM registers the address).
REQ-013 wave_on  out  1  registered pixel-on flag for the waveform trace.
REQ-014 busy  out  1  high while the FSM is in ARMED or CAPTURE.
REQ-015 done  out  1  high while the FSM is in DONE.

Function
REQ-016 The capture FSM SHALL have four states: IDLE, ARMED, CAPTURE and DONE.
REQ-017 In IDLE or DONE, arm=1 SHALL move the FSM to ARMED on the next clk; arm in ARMED or CAPTURE SHALL be ignored.
REQ-018 Register last_s SHALL load probe on every sample_tick, in all states.
REQ-019 Trigger SHALL fire in ARMED on a sample_tick where probe[trig_sel]=1 and last_s[trig_sel]=0; trig_sel=7 SHALL fire on the first sample_tick in ARMED.
REQ-020 On trigger, probe SHALL be written to buf[0], wr_idx set to 1, and the FSM moved to CAPTURE.
REQ-021 In CAPTURE, each sample_tick SHALL write probe to buf[wr_idx] and increment wr_idx; the write of index NUM_SAMPLES-1 SHALL move the FSM to DONE (no wrap-around).
REQ-022 sample_tick without a trigger condition in ARMED SHALL leave buf unchanged.
REQ-023 Render decode per pixel: col=pixel_x[9:3], ch=pixel_y[8:6], row=pixel_y[5:0], in_region = video_on & col<NUM_SAMPLES & ch<NUM_CH.
REQ-024 rom_addr SHALL be combinational from the current pixel: {buf[col-1][ch], buf[col][ch], row}; for col=0 the previous sample SHALL equal the current one; when not in_region, rom_addr SHALL be 0.
REQ-025 pixel_x[2:0] and in_region SHALL be delayed one clk to align with rom_data.
REQ-026 wave_on SHALL be registered as rom_data[7 - x_d[2:0]] & in_region_d, giving a latency of exactly 2 clk from pixel coordinates to wave_on.
REQ-027 Display reads SHALL use buf continuously in every state; mixed old/new data during CAPTURE is acceptable.
REQ-028 A write and a read of the same buf index in the same cycle SHALL return the old value.

Reset
REQ-029 reset SHALL force: FSM=IDLE, wr_idx=0, last_s=0, every buf entry=0, wave_on=0, busy=0, done=0.
REQ-030 reset SHALL take priority over arm and sample_tick, and SHALL abort a capture already in progress.

Verification
REQ-031 reset, then arm, trig_sel=2, probe[2] toggling 0->1 on the 3rd tick -> busy=1 after arm; CAPTURE entered on the 3rd tick; done=1 after 80 further-indexed writes (79 more ticks).
REQ-032 trig_sel=7, arm, probe=7'h55 on every tick -> capture starts on the first tick and all buf entries equal 7'h55.
REQ-033 After a capture with ch0 pattern 0,1,1,0: pixel (x=8..15, y=0..63) -> rom_addr[7:6]=01; (x=16..23) -> 11; (x=24..31) -> 10; x=0 -> 00. wave_on follows the ROM bit 2 clk later.
REQ-034 pixel_x>=640, pixel_y>=448 or video_on=0 -> rom_addr=0 and wave_on=0 two clk later.
REQ-035 reset asserted mid-CAPTURE (wr_idx=40) -> next clk FSM=IDLE, busy=0, buf all zero; a subsequent arm starts a fresh capture.
REQ-036 arm pulsed during ARMED and during CAPTURE -> no change to state or wr_idx.

Source files
------------

// File: rtl/logic_wave_sequencer.sv
// Triggered logic-analyzer capture of NUM_CH probes into a NUM_SAMPLES-deep buffer,
// rendered as square-wave tiles through an external registered-address ROM.
module logic_wave_sequencer #(
    parameter int NUM_CH      = 7,
    parameter int NUM_SAMPLES = 80
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] probe,
    input  logic              sample_tick,
    input  logic              arm,
    input  logic [2:0]        trig_sel,
    input  logic              video_on,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    output logic [7:0]        rom_addr,
    input  logic [7:0]        rom_data,
    output logic              wave_on,
    output logic              busy,
    output logic              done
);
    localparam int          IDX_W       = $clog2(NUM_SAMPLES + 1);
    localparam logic [7:0]  SAMPLES_LIM = 8'(NUM_SAMPLES);
    localparam logic [3:0]  CH_LIM      = 4'(NUM_CH);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  wr_idx_reg, wr_idx_next;
    logic [IDX_W-1:0]  wr_addr;
    logic              wr_en;
    logic              trig_hit;
    logic [NUM_CH-1:0] last_s_reg;
    logic [NUM_CH-1:0] sample_buf [NUM_SAMPLES];

    // ---------------- capture FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            wr_idx_reg <= '0;
            last_s_reg <= '0;
        end else begin
            state_reg  <= state_next;
            wr_idx_reg <= wr_idx_next;
            if (sample_tick)
                last_s_reg <= probe;
        end
    end

    always_comb begin
        state_next  = state_reg;
        wr_idx_next = wr_idx_reg;
        wr_en       = 1'b0;
        wr_addr     = wr_idx_reg;
        trig_hit    = 1'b0;
        // trig_sel of 7 is a forced trigger; other out-of-range channels never fire
        if (trig_sel == 3'd7)
            trig_hit = 1'b1;
        else if ({1'b0, trig_sel} < CH_LIM)
            trig_hit = probe[trig_sel] & ~last_s_reg[trig_sel];

        case (state_reg)
            IDLE, DONE: begin
                if (arm)
                    state_next = ARMED;
            end
            ARMED: begin
                if (sample_tick && trig_hit) begin
                    wr_en       = 1'b1;
                    wr_addr     = '0;
                    wr_idx_next = IDX_W'(1);
                    state_next  = CAPTURE;
                end
            end
            CAPTURE: begin
                if (sample_tick) begin
                    wr_en       = 1'b1;
                    wr_idx_next = wr_idx_reg + 1'b1;
                    if (wr_idx_reg == IDX_W'(NUM_SAMPLES - 1))
                        state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg == ARMED) || (state_reg == CAPTURE);
    assign done = (state_reg == DONE);

    // Register-based buffer: it must clear in one reset cycle and is read combinationally,
    // so a same-cycle write still shows the old value to the renderer.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SAMPLES; i++)
                sample_buf[i] <= '0;
        end else if (wr_en) begin
            sample_buf[wr_addr] <= probe;
        end
    end

    // ---------------- render path ----------------
    logic [6:0] col;
    logic [2:0] ch;
    logic [5:0] row;
    logic       in_region;
    logic       cur_bit, prev_bit;
    logic [2:0] x_d_reg;
    logic       in_region_d_reg;
    logic       wave_on_reg;

    assign col = pixel_x[9:3];
    assign ch  = pixel_y[8:6];
    assign row = pixel_y[5:0];
    // pixel_y[9] excludes lines 512+ so the 3-bit channel field cannot alias back to band 0
    assign in_region = video_on & ~pixel_y[9] & ({1'b0, col} < SAMPLES_LIM) & ({1'b0, ch} < CH_LIM);

    assign cur_bit  = sample_buf[col][ch];
    assign prev_bit = (col == 7'd0) ? cur_bit : sample_buf[col - 7'd1][ch];
    assign rom_addr = in_region ? {prev_bit, cur_bit, row} : 8'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_d_reg         <= '0;
            in_region_d_reg <= 1'b0;
            wave_on_reg     <= 1'b0;
        end else begin
            x_d_reg         <= pixel_x[2:0];
            in_region_d_reg <= in_region;
            wave_on_reg     <= rom_data[3'd7 - x_d_reg] & in_region_d_reg;
        end
    end

    assign wave_on = wave_on_reg;

endmodule

// File: tb/tb_logic_wave_sequencer.sv
// Randomized directed bench: capture outcomes and rendered pixels are predicted from the
// sequence of probe ticks the bench itself applies, plus a random ROM image.
module tb_logic_wave_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] probe = '0;
    logic       sample_tick = 1'b0;
    logic       arm = 1'b0;
    logic [2:0] trig_sel = '0;
    logic       video_on = 1'b0;
    logic [9:0] pixel_x = '0;
    logic [9:0] pixel_y = '0;
    logic [7:0] rom_addr;
    logic [7:0] rom_data = '0;
    logic       wave_on, busy, done;

    logic [7:0] rom_mem [256];

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    logic_wave_sequencer #(.NUM_CH(7), .NUM_SAMPLES(80)) dut (
        .clk(clk), .reset(reset), .probe(probe), .sample_tick(sample_tick), .arm(arm),
        .trig_sel(trig_sel), .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .rom_addr(rom_addr), .rom_data(rom_data), .wave_on(wave_on), .busy(busy), .done(done)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: every tick since reset, plus where the current arm began.
    logic [6:0] hist [$];
    logic [6:0] exp_buf [80];
    bit         m_active = 1'b0;
    bit         m_done = 1'b0;
    int         arm_pos = 0;
    int         trig_pos = -1;
    logic       wq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic void model_after_tick();
        if (!m_active) return;
        if (trig_pos < 0) begin
            for (int j = arm_pos; j < hist.size(); j++) begin
                logic [6:0] pv;
                logic [6:0] cv;
                pv = (j == 0) ? 7'd0 : hist[j-1];
                cv = hist[j];
                if (trig_sel == 3'd7 || (cv[trig_sel] && !pv[trig_sel])) begin
                    trig_pos = j;
                    break;
                end
            end
        end
        if (trig_pos >= 0) begin
            for (int k = 0; k < 80 && trig_pos + k < hist.size(); k++)
                exp_buf[k] = hist[trig_pos + k];
            if (hist.size() - trig_pos >= 80) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end
    endfunction

    function automatic logic [7:0] exp_addr(input int x, input int y, input logic v);
        logic cur, prv;
        int   col, ch;
        if (!(v && x < 640 && y < 448)) return 8'd0;
        col = x / 8;
        ch  = y / 64;
        cur = exp_buf[col][ch];
        prv = (col == 0) ? cur : exp_buf[col-1][ch];
        return {prv, cur, 6'(y % 64)};
    endfunction

    task automatic check_status(input string tag);
        chk({tag, "_busy"}, busy, m_active);
        chk({tag, "_done"}, done, m_done && !m_active);
    endtask

    task automatic do_tick(input logic [6:0] p);
        probe = p;
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        hist.push_back(p);
        model_after_tick();
        check_status("tick");
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    endtask

    task automatic do_arm();
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        if (!m_active) begin
            m_active = 1'b1;
            m_done   = 1'b0;
            arm_pos  = hist.size();
            trig_pos = -1;
        end
        check_status("arm");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        hist.delete();
        m_active = 1'b0;
        m_done   = 1'b0;
        trig_pos = -1;
        for (int i = 0; i < 80; i++) exp_buf[i] = '0;
        check_status("reset");
        chk("reset_wave_on", wave_on, 1'b0);
    endtask

    task automatic pix(input int x, input int y, input logic v);
        logic [7:0] e;
        logic       w;
        @(posedge clk); #1;
        if (wq.size() == 2) begin
            w = wq.pop_front();
            chk("wave_on", wave_on, w);
        end
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = v;
        #1;
        e = exp_addr(x, y, v);
        chk("rom_addr", rom_addr, e);
        w = (v && x < 640 && y < 448) ? rom_mem[e][7 - (x % 8)] : 1'b0;
        wq.push_back(w);
    endtask

    task automatic flush();
        pix(0, 0, 1'b0);
        pix(0, 0, 1'b0);
    endtask

    task automatic scan_all();
        wq.delete();
        for (int ch = 0; ch < 7; ch++)
            for (int col = 0; col < 80; col++)
                pix(col * 8 + int'($urandom_range(0, 7)), ch * 64 + int'($urandom_range(0, 63)), 1'b1);
        flush();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        scan_all();

        // Channel-2 rising edge on the third tick; extra arms while busy are ignored.
        trig_sel = 3'd2;
        do_arm();
        do_tick(7'($urandom) & 7'h7b);
        do_arm();
        do_tick(7'($urandom) & 7'h7b);
        do_tick(7'($urandom) | 7'h04);
        for (int t = 0; t < 78; t++) begin
            do_tick(7'($urandom));
            if (t == 20) do_arm();
        end
        chk("r031_done_before_last", done, 1'b0);
        do_tick(7'($urandom));
        chk("r031_done", done, 1'b1);
        chk("r031_busy", busy, 1'b0);
        scan_all();

        // Forced trigger with a constant pattern, then ticks after DONE must not write.
        trig_sel = 3'd7;
        do_arm();
        for (int t = 0; t < 80; t++) do_tick(7'h55);
        chk("r032_done", done, 1'b1);
        for (int t = 0; t < 5; t++) do_tick(7'h2a);
        scan_all();

        // Channel-0 pattern 0,1,1,0 at the start of the buffer.
        do_arm();
        do_tick(7'($urandom) & 7'h7e);
        do_tick(7'($urandom) | 7'h01);
        do_tick(7'($urandom) | 7'h01);
        do_tick(7'($urandom) & 7'h7e);
        for (int t = 0; t < 76; t++) do_tick(7'($urandom));
        wq.delete();
        pix(int'($urandom_range(0, 7)), int'($urandom_range(0, 63)), 1'b1);
        chk("r033_x0", rom_addr[7:6], 2'b00);
        pix(8 + int'($urandom_range(0, 7)), int'($urandom_range(0, 63)), 1'b1);
        chk("r033_x8", rom_addr[7:6], 2'b01);
        pix(16 + int'($urandom_range(0, 7)), int'($urandom_range(0, 63)), 1'b1);
        chk("r033_x16", rom_addr[7:6], 2'b11);
        pix(24 + int'($urandom_range(0, 7)), int'($urandom_range(0, 63)), 1'b1);
        chk("r033_x24", rom_addr[7:6], 2'b10);
        flush();
        scan_all();

        // Pixels outside the active waveform area.
        wq.delete();
        for (int i = 0; i < 40; i++) begin
            pix(640 + int'($urandom_range(0, 159)), int'($urandom_range(0, 524)), 1'b1);
            pix(int'($urandom_range(0, 639)), 448 + int'($urandom_range(0, 76)), 1'b1);
            pix(int'($urandom_range(0, 639)), int'($urandom_range(0, 447)), 1'b0);
            pix(int'($urandom_range(0, 639)), int'($urandom_range(0, 447)), 1'b1);
        end
        flush();

        // Reset in the middle of a capture, then a fresh capture.
        trig_sel = 3'd7;
        do_arm();
        for (int t = 0; t < 40; t++) do_tick(7'($urandom));
        chk("r035_busy_before", busy, 1'b1);
        do_reset();
        scan_all();
        trig_sel = 3'd3;
        do_arm();
        for (int t = 0; t < 1000 && !m_done; t++) do_tick(7'($urandom));
        chk("r035_fresh_done", done, 1'b1);
        scan_all();

        // Random trigger channels with random probe traffic.
        for (int r = 0; r < 3; r++) begin
            trig_sel = 3'($urandom_range(0, 6));
            do_arm();
            for (int t = 0; t < 1000 && !m_done; t++) do_tick(7'($urandom));
            chk("rand_done", done, 1'b1);
            scan_all();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
